mem_arbiter: RTL and testbench

Two-port arbiter and sequencer sharing the single unified 1024-word instruction/data memory of the multicycle CPU between the instruction-fetch path (IF state) and the data path (LW/SW in MEM state). It accepts word requests from both sides and serializes them onto one single-port memory interface with a wait-state handshake. Each access is guarded by a timeout watchdog. Requesters see a grant pulse, then a done pulse with read data.

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter serializing word accesses onto one single-port memory
// Build macro ARB_ROUND_ROBIN_EN selects round-robin tie-break; default gives the data port fixed priority.
module mem_arbiter #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [31:0]   d_rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;  // 1 = data port owns the access
  logic          last_q, last_d;    // 1 = data port won the most recent arbitration
  logic [7:0]    cnt_q, cnt_d;
  logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic          if_done_q, if_done_d, d_done_q, d_done_d;
  logic          err_q, err_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          pick_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_data = d_req & (~if_req | ~last_q);
`else
  assign pick_data = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (if_req || d_req) begin
          state_d  = ACCESS;
          owner_d  = pick_data;
          last_d   = pick_data;
          cnt_d    = 8'd0;
          mem_en_d = 1'b1;
          if (pick_data) begin
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr[AW+1:2];
            mem_wdata_d = d_wdata;
          end else begin
            if_gnt_d   = 1'b1;
            mem_addr_d = if_addr[AW+1:2];
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready || cnt_q == CNT_LAST) begin
          state_d   = DONE;
          err_d     = ~mem_ready;
          d_done_d  = owner_q;
          if_done_d = ~owner_q;
          // Read data is only taken on a real completion, never on a watchdog abort.
          if (mem_ready) begin
            if (!owner_q) begin
              if_rdata_d = mem_rdata;
            end else if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          cnt_d    = cnt_q + 8'd1;
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= 8'd0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Tie-break expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;
  localparam int AW  = 10;
  localparam int TMO = 15;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [2:0] TIE_D      = 3'b010;
  localparam logic       POST_RST_D = 1'b0;
`else
  localparam logic [2:0] TIE_D      = 3'b111;
  localparam logic       POST_RST_D = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we, mem_ready;
  logic [31:0]   if_addr, d_addr, d_wdata;
  logic          if_gnt, if_done, d_gnt, d_done, err, mem_en, mem_we;
  logic [31:0]   if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem [0:1023];
  int            checks = 0;
  int            failures = 0;

  mem_arbiter #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_en && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 0);
    chk({tag, "_if_done"}, 32'(if_done), 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_gnt"}, 32'(d_gnt), 0);
    chk({tag, "_d_done"}, 32'(d_done), 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ready = 1'b1;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    tick; tick;
    chk_zero("rst");
    reset = 1'b0;
    tick;

    // Single fetch, zero wait states
    if_req = 1; if_addr = 32'h8;
    tick;
    chk("f_gnt", 32'(if_gnt), 1);
    chk("f_d_gnt", 32'(d_gnt), 0);
    chk("f_mem_en", 32'(mem_en), 1);
    chk("f_mem_addr", 32'(mem_addr), 2);
    chk("f_mem_we", 32'(mem_we), 0);
    tick;
    chk("f_gnt_pulse", 32'(if_gnt), 0);
    chk("f_done", 32'(if_done), 1);
    chk("f_err", 32'(err), 0);
    chk("f_rdata", if_rdata, 32'h1000_0002);
    chk("f_en_off", 32'(mem_en), 0);
    if_req = 0;
    tick;
    chk("f_done_pulse", 32'(if_done), 0);

    // Store followed back-to-back by a load of the same word
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hA5A5_A5A5;
    tick;
    chk("st_gnt", 32'(d_gnt), 1);
    chk("st_we", 32'(mem_we), 1);
    chk("st_addr", 32'(mem_addr), 4);
    chk("st_wdata", mem_wdata, 32'hA5A5_A5A5);
    tick;
    chk("st_done", 32'(d_done), 1);
    chk("st_rdata_kept", d_rdata, 0);
    chk("st_we_off", 32'(mem_we), 0);
    d_we = 0;
    tick;
    chk("ld_gnt", 32'(d_gnt), 1);
    chk("ld_we", 32'(mem_we), 0);
    chk("ld_addr", 32'(mem_addr), 4);
    tick;
    chk("ld_done", 32'(d_done), 1);
    chk("ld_rdata", d_rdata, 32'hA5A5_A5A5);
    d_req = 0;
    tick;

    // Three consecutive ties
    if_req = 1; d_req = 1; if_addr = 32'hC; d_addr = 32'h20; d_we = 0;
    for (int r = 0; r < 3; r++) begin
      tick;
      chk("tie_d_gnt", 32'(d_gnt), 32'(TIE_D[r]));
      chk("tie_if_gnt", 32'(if_gnt), 32'(!TIE_D[r]));
      tick;
      chk("tie_d_done", 32'(d_done), 32'(TIE_D[r]));
      chk("tie_if_done", 32'(if_done), 32'(!TIE_D[r]));
      if (TIE_D[r]) chk("tie_d_rdata", d_rdata, 32'h1000_0008);
      else chk("tie_if_rdata", if_rdata, 32'h1000_0003);
    end
    if_req = 0; d_req = 0;
    tick;

    // Three wait states
    mem_ready = 0; if_req = 1; if_addr = 32'h40;
    tick;
    chk("ws_gnt", 32'(if_gnt), 1);
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk("ws_en", 32'(mem_en), 1);
      chk("ws_addr", 32'(mem_addr), 16);
      chk("ws_we", 32'(mem_we), 0);
      chk("ws_gnt_low", 32'(if_gnt), 0);
      chk("ws_done_low", 32'(if_done), 0);
    end
    mem_ready = 1;
    tick;
    chk("ws_done", 32'(if_done), 1);
    chk("ws_err", 32'(err), 0);
    chk("ws_rdata", if_rdata, 32'h1000_0010);
    if_req = 0;
    tick;

    // Watchdog timeout, then a normal retry
    mem_ready = 0; d_req = 1; d_we = 0; d_addr = 32'h24;
    tick;
    chk("to_gnt", 32'(d_gnt), 1);
    for (int k = 1; k < TMO; k++) begin
      tick;
      chk("to_wait_done", 32'(d_done), 0);
      chk("to_wait_en", 32'(mem_en), 1);
    end
    tick;
    chk("to_done", 32'(d_done), 1);
    chk("to_err", 32'(err), 1);
    chk("to_rdata_kept", d_rdata, 32'h1000_0008);
    chk("to_en_off", 32'(mem_en), 0);
    d_req = 0; mem_ready = 1;
    tick;
    chk("to_err_pulse", 32'(err), 0);
    d_req = 1;
    tick;
    chk("rt_gnt", 32'(d_gnt), 1);
    tick;
    chk("rt_done", 32'(d_done), 1);
    chk("rt_err", 32'(err), 0);
    chk("rt_rdata", d_rdata, 32'h1000_0009);
    d_req = 0;
    tick;

    // Reset during a stalled fetch
    mem_ready = 0; if_req = 1; if_addr = 32'h4;
    tick;
    chk("ra_gnt", 32'(if_gnt), 1);
    tick;
    chk("ra_en", 32'(mem_en), 1);
    #2 reset = 1'b1;
    #1 chk_zero("ra_async");
    d_req = 1;
    tick;
    chk_zero("ra_held");
    reset = 1'b0; mem_ready = 1;
    tick;
    chk("pr_d_gnt", 32'(d_gnt), 32'(POST_RST_D));
    chk("pr_if_gnt", 32'(if_gnt), 32'(!POST_RST_D));
    tick;
    chk("pr_d_done", 32'(d_done), 32'(POST_RST_D));
    chk("pr_if_done", 32'(if_done), 32'(!POST_RST_D));
    if (POST_RST_D) d_req = 0; else if_req = 0;
    tick;
    chk("pr2_d_gnt", 32'(d_gnt), 32'(!POST_RST_D));
    chk("pr2_if_gnt", 32'(if_gnt), 32'(POST_RST_D));
    tick;
    chk("pr2_done", 32'(if_done | d_done), 1);
    if_req = 0; d_req = 0;
    chk("pr_if_rdata", if_rdata, 32'h1000_0001);
    chk("pr_d_rdata", d_rdata, 32'h1000_0009);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
